ads131_spi_frame_master: RTL and testbench

Parametrised SPI master for the ADS131A0x ADC family. It runs the power-up reset sequence with configurable timing. It then captures one full data frame (status word plus NUM_CH channel words) on every DRDY falling edge, while shifting out a command word in the first word slot. It sits between the ADC pins and the sample-processing logic and replaces the single-transaction SPI master with a frame engine driven by data-ready.

---
 rtl/ads131_spi_frame_master_if.sv | 55 +++++
 rtl/ads131_spi_frame_master.sv | 214 +++++++++++++++++++++
 tb/tb_ads131_spi_frame_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads131_spi_frame_master_if.sv
`default_nettype none
// ============================================================================
// Module : ads131_spi_frame_master_if -- ADC pins + frame bus (ADS131_FRAME_CNT_EN adds frame_count)
// Rev    : 1.0
// ============================================================================
interface ads131_spi_frame_master_if #(
    parameter int NUM_CH    = 4,
    parameter int WORD_BITS = 24
);
    logic                              adc_init;
    logic                              adc_drdy_n;
    logic [WORD_BITS-1:0]              cmd_word;
    logic                              SPI_MISO;
    logic                              SPI_MOSI;
    logic                              SPI_SCLK;
    logic                              SPI_CS;
    logic                              SPI_RESET;
    logic [(NUM_CH+1)*WORD_BITS-1:0]   frame_data;
    logic                              frame_valid;
    logic                              init_done;
    logic                              busy;
    logic                              overrun;
    logic [2:0]                        state;

`ifdef ADS131_FRAME_CNT_EN
    logic [15:0]                       frame_count;

    modport master (
        input  adc_init, adc_drdy_n, cmd_word, SPI_MISO,
        output SPI_MOSI, SPI_SCLK, SPI_CS, SPI_RESET,
        output frame_data, frame_valid, init_done, busy, overrun, state,
        output frame_count
    );

    modport slave (
        output adc_init, adc_drdy_n, cmd_word, SPI_MISO,
        input  SPI_MOSI, SPI_SCLK, SPI_CS, SPI_RESET,
        input  frame_data, frame_valid, init_done, busy, overrun, state,
        input  frame_count
    );
`else
    modport master (
        input  adc_init, adc_drdy_n, cmd_word, SPI_MISO,
        output SPI_MOSI, SPI_SCLK, SPI_CS, SPI_RESET,
        output frame_data, frame_valid, init_done, busy, overrun, state
    );

    modport slave (
        output adc_init, adc_drdy_n, cmd_word, SPI_MISO,
        input  SPI_MOSI, SPI_SCLK, SPI_CS, SPI_RESET,
        input  frame_data, frame_valid, init_done, busy, overrun, state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ads131_spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module : ads131_spi_frame_master -- DRDY-driven ADS131A0x SPI frame engine
// Rev    : 1.0  | ADS131_FRAME_CNT_EN adds a 16-bit frame counter
// ============================================================================
module ads131_spi_frame_master #(
    parameter int NUM_CH            = 4,
    parameter int WORD_BITS         = 24,
    parameter int RESET_LOW_CYCLES  = 20835,
    parameter int RESET_WAIT_CYCLES = 83340,
    parameter int CS_IDLE_CYCLES    = 8
) (
    input  wire logic                  synthesized_clock_4_167Mhz,
    input  wire logic                  reset_n,
    ads131_spi_frame_master_if.master  bus
);

    localparam int c_FRAME_BITS   = (NUM_CH + 1) * WORD_BITS;
    localparam int c_SHIFT_CYCLES = 2 * c_FRAME_BITS;
    localparam int c_MAX_A        = (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ? RESET_LOW_CYCLES : RESET_WAIT_CYCLES;
    localparam int c_MAX_B        = (CS_IDLE_CYCLES > c_SHIFT_CYCLES) ? CS_IDLE_CYCLES : c_SHIFT_CYCLES;
    localparam int c_CNT_LIMIT    = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W        = $clog2(c_CNT_LIMIT) + 1;

    localparam logic [c_CNT_W-1:0] c_LOW_LAST   = c_CNT_W'(RESET_LOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(RESET_WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(c_SHIFT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_IDLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_LOW  = 3'd1,
        S_RST_WAIT = 3'd2,
        S_READY    = 3'd3,
        S_CS_SETUP = 3'd4,
        S_SHIFT    = 3'd5,
        S_CS_HOLD  = 3'd6
    } state_t;

    state_t                    r_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_cs;
    logic                      r_sclk;
    logic                      r_mosi;
    logic                      r_spi_reset;
    logic [c_FRAME_BITS-1:0]   r_frame_data;
    logic                      r_frame_valid;
    logic                      r_init_done;
    logic                      r_busy;
    logic                      r_overrun;
    logic [WORD_BITS-1:0]      r_tx;
    logic [c_FRAME_BITS-2:0]   r_rx;

    logic [1:0]                r_drdy_sync;
    logic                      r_drdy_last;
    logic                      w_drdy_evt;

    // Sync chain idles high so release from reset never fakes a falling edge.
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_drdy_sync <= 2'b11;
            r_drdy_last <= 1'b1;
        end else begin
            r_drdy_sync <= {r_drdy_sync[0], bus.adc_drdy_n};
            r_drdy_last <= r_drdy_sync[1];
        end
    end

    assign w_drdy_evt = r_drdy_last & ~r_drdy_sync[1];

    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cs          <= 1'b1;
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_spi_reset   <= 1'b1;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_init_done   <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_tx          <= '0;
            r_rx          <= '0;
        end else begin
            r_frame_valid <= 1'b0;

            if (w_drdy_evt && (r_state != S_READY)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.adc_init) begin
                        r_state     <= S_RST_LOW;
                        r_cnt       <= '0;
                        r_spi_reset <= 1'b0;
                    end
                end

                S_RST_LOW: begin
                    if (r_cnt == c_LOW_LAST) begin
                        r_state     <= S_RST_WAIT;
                        r_cnt       <= '0;
                        r_spi_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_RST_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_state     <= S_READY;
                        r_cnt       <= '0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_READY: begin
                    if (bus.adc_init) begin
                        r_state     <= S_RST_LOW;
                        r_cnt       <= '0;
                        r_init_done <= 1'b0;
                        r_spi_reset <= 1'b0;
                    end else if (w_drdy_evt) begin
                        // Command is captured here so the caller may change it mid-frame.
                        r_state <= S_CS_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_tx    <= bus.cmd_word;
                        r_mosi  <= bus.cmd_word[WORD_BITS-1];
                    end
                end

                S_CS_SETUP: begin
                    r_state <= S_SHIFT;
                    r_cnt   <= '0;
                end

                S_SHIFT: begin
                    if (!r_cnt[0]) begin
                        // Zeros shift in behind the command, so later words send 0.
                        r_sclk <= 1'b1;
                        r_mosi <= r_tx[WORD_BITS-1];
                        r_tx   <= {r_tx[WORD_BITS-2:0], 1'b0};
                    end else begin
                        r_sclk <= 1'b0;
                        r_rx   <= {r_rx[c_FRAME_BITS-3:0], bus.SPI_MISO};
                    end

                    if (r_cnt == c_SHIFT_LAST) begin
                        r_state       <= S_CS_HOLD;
                        r_cnt         <= '0;
                        r_cs          <= 1'b1;
                        r_frame_data  <= {r_rx, bus.SPI_MISO};
                        r_frame_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_CS_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_cs        <= 1'b1;
                    r_sclk      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_spi_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef ADS131_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= 16'h0000;
        end else if (r_frame_valid) begin
            r_frame_count <= r_frame_count + 16'h0001;
        end
    end

    assign bus.frame_count = r_frame_count;
`endif

    assign bus.SPI_CS      = r_cs;
    assign bus.SPI_SCLK    = r_sclk;
    assign bus.SPI_MOSI    = r_mosi;
    assign bus.SPI_RESET   = r_spi_reset;
    assign bus.frame_data  = r_frame_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.init_done   = r_init_done;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ads131_spi_frame_master.sv
`default_nettype none
// Scoreboarded bench: an ADC slave model serves random frames; a monitor checks each frame_valid.
module tb_ads131_spi_frame_master;

    localparam int NUM_CH       = 2;
    localparam int WORD_BITS    = 8;
    localparam int RST_LOW      = 4;
    localparam int RST_WAIT     = 6;
    localparam int CS_IDLE      = 3;
    localparam int FRAME_BITS   = (NUM_CH + 1) * WORD_BITS;
    localparam int LATENCY      = 1 + 2 * FRAME_BITS;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ads131_spi_frame_master_if #(.NUM_CH(NUM_CH), .WORD_BITS(WORD_BITS)) bus();

    ads131_spi_frame_master #(
        .NUM_CH            (NUM_CH),
        .WORD_BITS         (WORD_BITS),
        .RESET_LOW_CYCLES  (RST_LOW),
        .RESET_WAIT_CYCLES (RST_WAIT),
        .CS_IDLE_CYCLES    (CS_IDLE)
    ) dut (
        .synthesized_clock_4_167Mhz (clk),
        .reset_n                    (reset_n),
        .bus                        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRAME_BITS-1:0] frame;
        logic [FRAME_BITS-1:0] mosi;
    } exp_t;

    exp_t                  exp_q[$];
    logic [FRAME_BITS-1:0] adc_q[$];
    int total = 0;
    int bad   = 0;
    int frames_seen = 0;
    int frames_exp  = 0;
    int sclk_rises  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ADC slave: reloads a frame on CS fall and launches one bit per SCLK rise.
    logic [FRAME_BITS-1:0] adc_sh;
    logic adc_prev_cs   = 1'b1;
    logic adc_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (adc_prev_cs && !bus.SPI_CS)
            adc_sh = (adc_q.size() != 0) ? adc_q.pop_front() : '0;
        if (!bus.SPI_CS && bus.SPI_SCLK && !adc_prev_sclk) begin
            bus.SPI_MISO = adc_sh[FRAME_BITS-1];
            adc_sh       = adc_sh << 1;
        end
        if (!reset_n) bus.SPI_MISO = 1'b0;
        adc_prev_cs   = bus.SPI_CS;
        adc_prev_sclk = bus.SPI_SCLK;
    end

    // Monitor: collects MOSI, times CS/busy, and pops the scoreboard on frame_valid.
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_fv = 1'b0, hold_pending = 1'b0;
    int   mon_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic [FRAME_BITS-1:0] mosi_bits = '0;
    exp_t mon_e;
    always @(negedge clk) begin
        mon_cyc++;
        if (!reset_n) begin
            hold_pending = 1'b0;
            sclk_rises   = 0;
        end else begin
            if (prev_cs && !bus.SPI_CS) begin
                cs_fall_cyc = mon_cyc;
                sclk_rises  = 0;
                mosi_bits   = '0;
            end
            if (bus.SPI_SCLK && !prev_sclk) begin
                sclk_rises++;
                mosi_bits = {mosi_bits[FRAME_BITS-2:0], bus.SPI_MOSI};
            end
            if (bus.frame_valid) begin
                frames_seen++;
                check("fv_single_cycle", prev_fv, 1'b0);
                check("fv_expected", exp_q.size() == 0, 1'b0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("frame_data", bus.frame_data, mon_e.frame);
                    check("mosi_stream", mosi_bits, mon_e.mosi);
                    check("latency", mon_cyc - cs_fall_cyc, LATENCY);
                    check("sclk_rises", sclk_rises, FRAME_BITS);
                    check("cs_high_at_fv", bus.SPI_CS, 1'b1);
                end
                cs_rise_cyc  = mon_cyc;
                hold_pending = 1'b1;
            end
            if (hold_pending && prev_busy && !bus.busy) begin
                check("busy_hold", mon_cyc - cs_rise_cyc, CS_IDLE);
                hold_pending = 1'b0;
            end
        end
        prev_cs   = bus.SPI_CS;
        prev_sclk = bus.SPI_SCLK;
        prev_busy = bus.busy;
        prev_fv   = bus.frame_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_init(input string tag);
        int low_cnt  = 0;
        int wait_cnt = 0;
        @(negedge clk) bus.adc_init = 1'b1;
        @(negedge clk) bus.adc_init = 1'b0;
        check({tag, "_init_done_clr"}, bus.init_done, 1'b0);
        while (bus.SPI_RESET == 1'b0 && low_cnt < 100) begin
            low_cnt++;
            @(negedge clk);
        end
        check({tag, "_reset_low"}, low_cnt, RST_LOW);
        while (!bus.init_done && wait_cnt < 200) begin
            wait_cnt++;
            @(negedge clk);
        end
        check({tag, "_reset_wait"}, wait_cnt, RST_WAIT);
        check({tag, "_ready_state"}, bus.state, 3);
    endtask

    task automatic start_frame(input logic [WORD_BITS-1:0] cmd, input logic [FRAME_BITS-1:0] data);
        exp_t e;
        int   t = 0;
        e.frame = data;
        e.mosi  = {cmd, {(FRAME_BITS - WORD_BITS){1'b0}}};
        exp_q.push_back(e);
        adc_q.push_back(data);
        frames_exp++;
        @(negedge clk);
        bus.cmd_word   = cmd;
        bus.adc_drdy_n = 1'b0;
        while (bus.SPI_CS && t < 10) begin
            t++;
            @(negedge clk);
        end
        check("cs_fall", bus.SPI_CS, 1'b0);
        check("busy_at_cs", bus.busy, 1'b1);
        bus.cmd_word = WORD_BITS'($urandom);
    endtask

    task automatic finish_frame();
        int t = 0;
        bus.adc_drdy_n = 1'b1;
        while (bus.busy && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("busy_release", bus.busy, 1'b0);
        wait_cycles($urandom_range(1, 5));
    endtask

    task automatic do_frame(input logic [WORD_BITS-1:0] cmd, input logic [FRAME_BITS-1:0] data);
        start_frame(cmd, data);
        wait_cycles(3);
        finish_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.adc_init   = 1'b0;
        bus.adc_drdy_n = 1'b1;
        bus.cmd_word   = '0;
        wait_cycles(3);

        check("rst_cs",        bus.SPI_CS,      1'b1);
        check("rst_sclk",      bus.SPI_SCLK,    1'b0);
        check("rst_mosi",      bus.SPI_MOSI,    1'b0);
        check("rst_spi_reset", bus.SPI_RESET,   1'b1);
        check("rst_frame",     bus.frame_data,  0);
        check("rst_fv",        bus.frame_valid, 1'b0);
        check("rst_init_done", bus.init_done,   1'b0);
        check("rst_busy",      bus.busy,        1'b0);
        check("rst_overrun",   bus.overrun,     1'b0);
        check("rst_state",     bus.state,       0);

        @(negedge clk) reset_n = 1'b1;
        wait_cycles(3);
        check("idle_hold", bus.state, 0);

        do_init("init");
        do_frame(8'h11, 24'h22A53C);
        check("frames_first", frames_seen, frames_exp);

        for (int i = 0; i < 6; i++)
            do_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));

        // Second DRDY edge mid-SHIFT must flag overrun and be dropped.
        check("overrun_clear", bus.overrun, 1'b0);
        start_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));
        wait_cycles(4);
        bus.adc_drdy_n = 1'b1;
        wait_cycles(16);
        bus.adc_drdy_n = 1'b0;
        wait_cycles(4);
        check("overrun_set", bus.overrun, 1'b1);
        check("overrun_in_shift", bus.state, 5);
        finish_frame();
        wait_cycles(10);
        check("no_second_cs", bus.SPI_CS, 1'b1);
        check("no_second_state", bus.state, 3);
        check("frames_overrun", frames_seen, frames_exp);
        do_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));
        check("overrun_sticky", bus.overrun, 1'b1);

        do_init("reinit");
        do_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));

        // Asynchronous reset part-way through SHIFT.
        start_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));
        t = 0;
        while (sclk_rises < 10 && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("reached_bit10", sclk_rises >= 10, 1'b1);
        #2 reset_n = 1'b0;
        exp_q.delete();
        frames_exp--;
        #1;
        check("arst_cs",        bus.SPI_CS,     1'b1);
        check("arst_sclk",      bus.SPI_SCLK,   1'b0);
        check("arst_state",     bus.state,      0);
        check("arst_fv",        bus.frame_valid, 1'b0);
        check("arst_busy",      bus.busy,       1'b0);
        check("arst_overrun",   bus.overrun,    1'b0);
        check("arst_frame",     bus.frame_data, 0);
        check("arst_init_done", bus.init_done,  1'b0);
        bus.adc_drdy_n = 1'b1;
        wait_cycles(4);
        @(negedge clk) reset_n = 1'b1;
        wait_cycles(2);
        check("frames_after_arst", frames_seen, frames_exp);

        do_init("post_arst");
        for (int i = 0; i < 3; i++)
            do_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));

`ifdef ADS131_FRAME_CNT_EN
        check("frame_count_3", bus.frame_count, 16'd3);
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        do_frame(WORD_BITS'($urandom), FRAME_BITS'($urandom));
        check("frame_count_wrap", bus.frame_count, 16'h0000);
`endif

        wait_cycles(5);
        check("frames_total", frames_seen, frames_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
